pwm_dead_time_driver: RTL



---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_dead_time_fsm.sv | 105 ++++++++++
 rtl/pwm_dead_time_driver.sv | 109 ++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared definitions for the PWM output stage and the sine-table duty
// stage that feeds it.
//   PWM_PERIOD  : PWM period in prescaled ticks (duty 0..PWM_PERIOD).
//   DUTY_W      : width of the duty word, wide enough to hold PWM_PERIOD.
//   pwm_state_t : states of the half-bridge dead-time sequencer.
package pwm_pkg;

    localparam int PWM_PERIOD = 64;
    localparam int DUTY_W     = 7;

    // ST_DT_LH / ST_DT_HL are the both-off gaps on the way low->high and
    // high->low respectively.
    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_LO    = 3'd1,
        ST_DT_LH = 3'd2,
        ST_HI    = 3'd3,
        ST_DT_HL = 3'd4
    } pwm_state_t;

endpackage

// File: rtl/pwm_dead_time_fsm.sv
// pwm_dead_time_fsm
// Turns the raw PWM comparison into a complementary gate-drive pair with a
// both-off gap of DEAD_TIME sysclk cycles at every commutation.
// Ports:
//   sysclk   in  system clock, rising edge
//   rst_n    in  asynchronous active-low reset
//   enable   in  bridge runs when 1; when 0 both devices are switched off
//   raw      in  requested phase: 1 = high side, 0 = low side
//   pwm_high out high-side gate drive (registered)
//   pwm_low  out low-side gate drive (registered)
module pwm_dead_time_fsm
    import pwm_pkg::*;
#(
    parameter int DEAD_TIME = 2
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic enable,
    input  logic raw,
    output logic pwm_high,
    output logic pwm_low
);

    localparam int DT_W = (DEAD_TIME > 2) ? $clog2(DEAD_TIME) : 1;
    localparam logic [DT_W-1:0] DT_LAST = (DEAD_TIME > 0) ? DT_W'(DEAD_TIME - 1) : '0;

    pwm_state_t      state;
    pwm_state_t      next_state;
    logic [DT_W-1:0] dt_cnt;
    logic [DT_W-1:0] next_dt_cnt;

    // A dead-time state remembers which device it came from: if the request
    // flips back before the gap has elapsed, that device may resume at once
    // because the opposite one was never switched on.
    always_comb begin
        next_state  = state;
        next_dt_cnt = dt_cnt;
        if (!enable) begin
            next_state  = ST_OFF;
            next_dt_cnt = '0;
        end else begin
            case (state)
                ST_OFF: begin
                    next_dt_cnt = '0;
                    if (DEAD_TIME == 0) begin
                        next_state = raw ? ST_HI : ST_LO;
                    end else begin
                        next_state = raw ? ST_DT_LH : ST_DT_HL;
                    end
                end
                ST_LO: begin
                    if (raw) begin
                        next_dt_cnt = '0;
                        next_state  = (DEAD_TIME == 0) ? ST_HI : ST_DT_LH;
                    end
                end
                ST_DT_LH: begin
                    if (!raw) begin
                        next_state = ST_LO;
                    end else if (dt_cnt == DT_LAST) begin
                        next_state = ST_HI;
                    end else begin
                        next_dt_cnt = dt_cnt + DT_W'(1);
                    end
                end
                ST_HI: begin
                    if (!raw) begin
                        next_dt_cnt = '0;
                        next_state  = (DEAD_TIME == 0) ? ST_LO : ST_DT_HL;
                    end
                end
                ST_DT_HL: begin
                    if (raw) begin
                        next_state = ST_HI;
                    end else if (dt_cnt == DT_LAST) begin
                        next_state = ST_LO;
                    end else begin
                        next_dt_cnt = dt_cnt + DT_W'(1);
                    end
                end
                default: begin
                    next_state  = ST_OFF;
                    next_dt_cnt = '0;
                end
            endcase
        end
    end

    // Outputs are registered decodes of the next state so they change in
    // the same cycle as the state register and can never glitch.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_OFF;
            dt_cnt   <= '0;
            pwm_high <= 1'b0;
            pwm_low  <= 1'b0;
        end else begin
            state    <= next_state;
            dt_cnt   <= next_dt_cnt;
            pwm_high <= (next_state == ST_HI);
            pwm_low  <= (next_state == ST_LO);
        end
    end

endmodule

// File: rtl/pwm_dead_time_driver.sv
// pwm_dead_time_driver
// Half-bridge PWM driver fed by the sine-table duty stage. A prescaled
// period counter is compared against a double-buffered duty shadow; the
// resulting raw phase drives a dead-time sequencer.
// Ports:
//   sysclk       in  system clock, rising edge
//   rst_n        in  asynchronous active-low reset
//   enable       in  run when 1; when 0 bridge off and counters held at 0
//   duty_in      in  requested duty count (0..PERIOD, larger is clamped)
//   pwm_high     out high-side gate drive
//   pwm_low      out low-side gate drive
//   period_start out one-cycle pulse as the period counter enters 0
//   duty_clamped out one-cycle pulse when a loaded duty exceeded PERIOD
module pwm_dead_time_driver #(
    parameter int PERIOD    = pwm_pkg::PWM_PERIOD,
    parameter int DUTY_W    = pwm_pkg::DUTY_W,
    parameter int PRESCALE  = 1,
    parameter int DEAD_TIME = 2
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DUTY_W-1:0] duty_in,
    output logic              pwm_high,
    output logic              pwm_low,
    output logic              period_start,
    output logic              duty_clamped
);

    import pwm_pkg::*;

    localparam int CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam int PS_W  = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(PRESCALE - 1);
    localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(PERIOD);

    logic [PS_W-1:0]   presc;
    logic [CNT_W-1:0]  cnt;
    logic [DUTY_W-1:0] shadow;
    logic              running;
    logic              tick;
    logic              wrap;
    logic              load;
    logic              over;
    logic              raw;

    assign tick = enable && (presc == PS_LAST);
    assign wrap = tick && (cnt == CNT_LAST);
    assign over = (duty_in > DUTY_FULL);

    // While disabled the shadow tracks duty_in every cycle, so the first
    // period after enable already uses the current request.
    assign load = !enable || wrap;

    assign raw = enable && (DUTY_W'(cnt) < shadow);

    // running marks that the previous cycle was enabled; its absence flags
    // the first cycle of a run, which also counts as a period start.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            presc        <= '0;
            cnt          <= '0;
            running      <= 1'b0;
            period_start <= 1'b0;
        end else if (!enable) begin
            presc        <= '0;
            cnt          <= '0;
            running      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            running      <= 1'b1;
            period_start <= !running || wrap;
            if (tick) begin
                presc <= '0;
                cnt   <= wrap ? '0 : cnt + CNT_W'(1);
            end else begin
                presc <= presc + PS_W'(1);
            end
        end
    end

    // Duty is only taken at the period boundary so a mid-period step from
    // the sine stage cannot cut a pulse short.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            shadow       <= '0;
            duty_clamped <= 1'b0;
        end else begin
            duty_clamped <= load && over;
            if (load) begin
                shadow <= over ? DUTY_FULL : duty_in;
            end
        end
    end

    pwm_dead_time_fsm #(
        .DEAD_TIME (DEAD_TIME)
    ) u_fsm (
        .sysclk   (sysclk),
        .rst_n    (rst_n),
        .enable   (enable),
        .raw      (raw),
        .pwm_high (pwm_high),
        .pwm_low  (pwm_low)
    );

endmodule
